// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Multi-cycle control unit for the hamming_parity core. It fetches 9-bit
// instructions from a synchronous-read instruction memory and decodes the
// 4-bit opcode. It drives the ALU opcode/argument, gates register-file
// writeback, resolves BNZ and HALT, and offers a start/done handshake.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   start       launch program at pc 0 (honoured only in IDLE or HALT)
//   busy        registered, high in FETCH/DECODE/EXEC
//   done        registered, high while in HALT
//   imem_addr   instruction address (always equals pc)
//   imem_rdata  instruction data, valid the cycle after the address
//   alu_op      opcode to ALU; PASS outside EXEC
//   alu_arg     5-bit argument to datapath; 0 outside EXEC
//   alu_zero    ALU result == 0, used only in EXEC of BNZ
//   rf_we       register-file write enable (single EXEC cycle)
//   illegal     sticky flag, set by a reserved opcode, cleared on launch
//   instr_cnt   saturating count of retired instructions since launch
module ctrl_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         alu_op,
    output logic [4:0]         alu_arg,
    input  logic               alu_zero,
    output logic               rf_we,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_cnt
);

    localparam logic [3:0] OP_PASS = 4'b1000;
    localparam logic [3:0] OP_BNZ  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic               illegal_reg, illegal_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [3:0]         ir_op;
    logic [4:0]         ir_arg;
    logic               start_ok;
    logic               op_reserved;
    logic [PC_W-1:0]    branch_off;

    assign ir_op       = ir_reg[INSTR_W-1 -: 4];
    assign ir_arg      = ir_reg[4:0];
    assign start_ok    = start && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));
    // 1010..1110 are reserved; 1111 is HALT.
    assign op_reserved = (ir_op >= 4'b1010) && (ir_op != OP_HALT);
    // Sign-extend the 5-bit branch offset to pc width; addition wraps mod 2^PC_W.
    assign branch_off  = {{(PC_W-5){ir_arg[4]}}, ir_arg};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        illegal_next = illegal_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                state_next = ST_EXEC;
                ir_next    = imem_rdata;
            end
            ST_EXEC: begin
                state_next = (ir_op == OP_HALT) ? ST_HALT : ST_FETCH;
                // HALT retires too, so the counter advances for every EXEC.
                if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + CNT_W'(1);
                if (op_reserved) illegal_next = 1'b1;
                if (ir_op == OP_HALT) begin
                    pc_next = pc_reg;
                end else if ((ir_op == OP_BNZ) && !alu_zero) begin
                    pc_next = pc_reg + branch_off;
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
            end
            ST_HALT:   if (start) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase

        // Launch resets the program context; only reachable from IDLE/HALT.
        if (start_ok) begin
            pc_next      = '0;
            illegal_next = 1'b0;
            cnt_next     = '0;
        end

        busy_next = (state_next == ST_FETCH) || (state_next == ST_DECODE) ||
                    (state_next == ST_EXEC);
        done_next = (state_next == ST_HALT);
    end

    // ---------------- output decode ----------------
    always_comb begin
        alu_op  = OP_PASS;
        alu_arg = 5'd0;
        rf_we   = 1'b0;
        if (state_reg == ST_EXEC) begin
            alu_arg = ir_arg;
            if (!ir_op[3]) begin
                alu_op = ir_op;
                // Reset in an EXEC cycle must suppress the in-flight write.
                rf_we  = rst_n;
            end
        end
    end

    assign imem_addr = pc_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign illegal   = illegal_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer. Main instance uses default widths;
// a second instance with CNT_W=4 covers counter saturation.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_s;
    logic        alu_zero;

    logic        busy, done, rf_we, illegal;
    logic [7:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic [3:0]  alu_op;
    logic [4:0]  alu_arg;
    logic [15:0] instr_cnt;

    logic        busy_s, done_s, rf_we_s, illegal_s;
    logic [7:0]  imem_addr_s;
    logic [8:0]  imem_rdata_s;
    logic [3:0]  alu_op_s;
    logic [4:0]  alu_arg_s;
    logic [3:0]  instr_cnt_s;

    logic [8:0]  mem   [256];
    logic [8:0]  mem_s [256];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata   <= mem[imem_addr];
    always @(posedge clk) imem_rdata_s <= mem_s[imem_addr_s];

    ctrl_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .alu_op(alu_op),
        .alu_arg(alu_arg), .alu_zero(alu_zero), .rf_we(rf_we),
        .illegal(illegal), .instr_cnt(instr_cnt)
    );

    ctrl_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s), .alu_op(alu_op_s),
        .alu_arg(alu_arg_s), .alu_zero(1'b0), .rf_we(rf_we_s),
        .illegal(illegal_s), .instr_cnt(instr_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] arg);
        return {op, arg};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = ins(4'hF, 5'd0);
    endtask

    // Launch: start high for one cycle T; returns settled in T+1.
    task automatic launch();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            step(1);
            k++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},    {31'd0, busy},      32'd0);
        chk({pfx, "_done"},    {31'd0, done},      32'd0);
        chk({pfx, "_addr"},    {24'd0, imem_addr}, 32'd0);
        chk({pfx, "_alu_op"},  {28'd0, alu_op},    32'h8);
        chk({pfx, "_alu_arg"}, {27'd0, alu_arg},   32'd0);
        chk({pfx, "_rf_we"},   {31'd0, rf_we},     32'd0);
        chk({pfx, "_illegal"}, {31'd0, illegal},   32'd0);
        chk({pfx, "_cnt"},     {16'd0, instr_cnt}, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; alu_zero = 1'b0;
        clear_mem();
        for (int i = 0; i < 256; i++) mem_s[i] = ins(4'hF, 5'd0);
        step(2);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step(1);
        $display("reset checked");

        // ---- Test 1: ADD 3, HALT ----
        mem[0] = ins(4'b0000, 5'd3);
        mem[1] = ins(4'hF, 5'd0);
        launch();                                   // T+1 FETCH
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_addr", {24'd0, imem_addr}, 32'd0);
        step(1);                                    // T+2 DECODE
        chk("t1_we_decode", {31'd0, rf_we}, 32'd0);
        step(1);                                    // T+3 EXEC
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_op", {28'd0, alu_op}, 32'h0);
        chk("t1_arg", {27'd0, alu_arg}, 32'd3);
        step(3);                                    // T+6 HALT EXEC
        chk("t1_done_exec", {31'd0, done}, 32'd0);
        step(1);                                    // T+7
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_cnt", {16'd0, instr_cnt}, 32'd2);
        $display("test1 add/halt done");

        // ---- Test 2: BNZ taken then not taken ----
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = ins(4'b1000, 5'd0);
        mem[4] = ins(4'b1001, 5'b11110);
        mem[5] = ins(4'hF, 5'd0);
        alu_zero = 1'b0;
        launch();
        step(14);                                   // T+15 EXEC of BNZ@4
        chk("t2_bnz_op", {28'd0, alu_op}, 32'h8);
        chk("t2_we_taken", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t2_taken_addr", {24'd0, imem_addr}, 32'd2);
        step(8);                                    // EXEC of BNZ@4 again
        alu_zero = 1'b1;
        #1;
        chk("t2_we_nt", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t2_nt_addr", {24'd0, imem_addr}, 32'd5);
        alu_zero = 1'b0;
        wait_done(20);
        $display("test2 bnz done");

        // ---- Test 3: wrap below 0 and past 0xFF ----
        clear_mem();
        mem[0]    = ins(4'b1000, 5'd0);
        mem[1]    = ins(4'b1001, 5'b11100);
        mem[2]    = ins(4'hF, 5'd0);
        mem[8'hFD] = ins(4'b1000, 5'd0);
        mem[8'hFE] = ins(4'b1000, 5'd0);
        mem[8'hFF] = ins(4'b1000, 5'd0);
        alu_zero = 1'b0;
        launch();
        step(6);                                    // T+7 after BNZ@1
        chk("t3_wrap_neg", {24'd0, imem_addr}, 32'hFD);
        step(9);                                    // T+16 after PASS@FF
        chk("t3_wrap_pos", {24'd0, imem_addr}, 32'h00);
        alu_zero = 1'b1;                            // second BNZ falls through
        wait_done(30);
        chk("t3_cnt", {16'd0, instr_cnt}, 32'd8);
        alu_zero = 1'b0;
        $display("test3 wrap done");

        // ---- Test 4: reserved opcode ----
        clear_mem();
        mem[0] = ins(4'b1011, 5'd7);
        mem[1] = ins(4'hF, 5'd0);
        launch();
        step(2);                                    // T+3 EXEC reserved
        chk("t4_we", {31'd0, rf_we}, 32'd0);
        chk("t4_ill_exec", {31'd0, illegal}, 32'd0);
        step(1);
        chk("t4_ill_set", {31'd0, illegal}, 32'd1);
        chk("t4_addr", {24'd0, imem_addr}, 32'd1);
        wait_done(20);
        chk("t4_ill_halt", {31'd0, illegal}, 32'd1);
        launch();
        chk("t4_ill_clr", {31'd0, illegal}, 32'd0);
        chk("t4_relaunch_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        $display("test4 reserved done");

        // ---- Test 5: start while busy, then reset during ADD EXEC ----
        clear_mem();
        mem[0] = ins(4'b0000, 5'd1);
        mem[1] = ins(4'b0001, 5'd2);
        mem[2] = ins(4'hF, 5'd0);
        launch();                                   // T+1 FETCH
        step(1);                                    // T+2 DECODE
        start = 1'b1;
        step(1);                                    // T+3 EXEC
        start = 1'b0;
        chk("t5_arg", {27'd0, alu_arg}, 32'd1);
        step(1);
        chk("t5_addr_seq", {24'd0, imem_addr}, 32'd1);
        step(2);                                    // EXEC of ADD@1
        chk("t5_we_pre", {31'd0, rf_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_we_rst", {31'd0, rf_we}, 32'd0);
        step(1);
        chk_reset_outputs("t5");
        rst_n = 1'b1;
        step(1);
        $display("test5 busy-start/reset done");

        // ---- Test 6: counter saturation with CNT_W=4 ----
        for (int i = 0; i < 19; i++) mem_s[i] = ins(4'b1000, 5'd0);
        mem_s[19] = ins(4'hF, 5'd0);
        start_s = 1'b1;
        step(1);
        start_s = 1'b0;
        k = 0;
        while (!done_s && k < 100) begin
            step(1);
            k++;
        end
        chk("t6_done", {31'd0, done_s}, 32'd1);
        chk("t6_cnt_sat", {28'd0, instr_cnt_s}, 32'd15);
        $display("test6 saturation done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
